native_to_ddr_app: RTL

Upstream bridge between the AXI4-to-native converter and the DDR controller user (app) interface. It accepts single-beat native read/write requests, and drives the app command and write-data channels independently under `app_rdy`/`app_wdf_rdy` backpressure. It also buffers returning read data in a credit-protected FIFO, because the app read channel cannot be stalled. One request produces one app command and, for writes, exactly one data beat (`app_wdf_end` always set).

---
 rtl/native_to_ddr_app_if.sv | 46 ++++
 rtl/native_to_ddr_app.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/native_to_ddr_app_if.sv
// Native request/response and DDR app command, write-data and read-return signals
// between the native master, the bridge and the memory controller.
interface native_to_ddr_app_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 256
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  init_calib_complete;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [MASK_WIDTH-1:0] req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic                  app_rdy;
    logic [DATA_WIDTH-1:0] app_wdf_data;
    logic [MASK_WIDTH-1:0] app_wdf_mask;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_wdf_rdy;
    logic [DATA_WIDTH-1:0] app_rd_data;
    logic                  app_rd_data_valid;
    logic                  app_rd_data_end;

    // Environment view: native requester plus memory controller.
    modport master (
        output init_calib_complete, req_valid, req_write, req_addr, req_wdata, req_wstrb,
               rsp_ready, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  req_ready, rsp_valid, rsp_data, app_addr, app_cmd, app_en,
               app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );

    modport slave (
        input  init_calib_complete, req_valid, req_write, req_addr, req_wdata, req_wstrb,
               rsp_ready, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        output req_ready, rsp_valid, rsp_data, app_addr, app_cmd, app_en,
               app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/native_to_ddr_app.sv
// Native single-beat requests -> DDR app cmd/wdf channels (1 cycle), read data via credit-limited FIFO (1 cycle).
// Accepts stall while a cmd/data beat is pending or credits are 0; NATIVE_APP_STAT_EN adds write/read counters.
module native_to_ddr_app #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 256,
    parameter int RD_DEPTH   = 16
) (
    input  logic clock,
    input  logic rst,
    native_to_ddr_app_if.slave bus
`ifdef NATIVE_APP_STAT_EN
    ,
    output logic [31:0] stat_wr_cnt,
    output logic [31:0] stat_rd_cnt
`endif
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(RD_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RD_DEPTH);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic                  live_q;
    logic                  cmd_pend_q, cmd_pend_d;
    logic                  cmd_rd_q, cmd_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wd_pend_q, wd_pend_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic [CNT_W-1:0]      credits_q, credits_d;
    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [RD_DEPTH];

    logic req_rdy, req_acc, rd_acc, rsp_pop;
    logic fifo_empty, fifo_full, fifo_push;
    logic unused_rd_end;

    assign unused_rd_end = bus.app_rd_data_end;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        // live_q keeps req_ready low while reset is asserted.
        req_rdy    = live_q && bus.init_calib_complete && !cmd_pend_q && !wd_pend_q &&
                     (credits_q != '0);
        req_acc    = bus.req_valid && req_rdy;
        rd_acc     = req_acc && !bus.req_write;
        rsp_pop    = !fifo_empty && bus.rsp_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still take a beat.
        fifo_push  = bus.app_rd_data_valid && (!fifo_full || rsp_pop);

        cmd_pend_d = cmd_pend_q;
        cmd_rd_d   = cmd_rd_q;
        addr_d     = addr_q;
        wd_pend_d  = wd_pend_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        credits_d  = credits_q;

        if (cmd_pend_q && bus.app_rdy)     cmd_pend_d = 1'b0;
        if (wd_pend_q && bus.app_wdf_rdy)  wd_pend_d  = 1'b0;

        if (req_acc) begin
            cmd_pend_d = 1'b1;
            cmd_rd_d   = !bus.req_write;
            addr_d     = bus.req_addr;
            if (bus.req_write) begin
                wd_pend_d = 1'b1;
                wdata_d   = bus.req_wdata;
                wmask_d   = ~bus.req_wstrb;
            end
        end

        if (rd_acc && !rsp_pop)      credits_d = credits_q - ONE;
        else if (rsp_pop && !rd_acc) credits_d = credits_q + ONE;

        wr_ptr_d = wr_ptr_q + CNT_W'(fifo_push);
        rd_ptr_d = rd_ptr_q + CNT_W'(rsp_pop);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            live_q     <= 1'b0;
            cmd_pend_q <= 1'b0;
            cmd_rd_q   <= 1'b0;
            addr_q     <= '0;
            wd_pend_q  <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '1;
            credits_q  <= CREDIT_MAX;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            live_q     <= 1'b1;
            cmd_pend_q <= cmd_pend_d;
            cmd_rd_q   <= cmd_rd_d;
            addr_q     <= addr_d;
            wd_pend_q  <= wd_pend_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            credits_q  <= credits_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: rsp_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (fifo_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.app_rd_data;
    end

    rd_fifo_no_overflow: assert property (@(posedge clock) disable iff (rst)
        !(bus.app_rd_data_valid && fifo_full && !rsp_pop))
        else $error("native_to_ddr_app: read beat arrived with FIFO full, beat dropped");

    assign bus.req_ready    = req_rdy;
    assign bus.app_en       = cmd_pend_q;
    assign bus.app_cmd      = {2'b00, cmd_rd_q};
    assign bus.app_addr     = addr_q;
    assign bus.app_wdf_wren = wd_pend_q;
    assign bus.app_wdf_end  = wd_pend_q;
    assign bus.app_wdf_data = wdata_q;
    assign bus.app_wdf_mask = wmask_q;
    assign bus.rsp_valid    = !fifo_empty;
    assign bus.rsp_data     = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

`ifdef NATIVE_APP_STAT_EN
    logic [31:0] stat_wr_cnt_q, stat_wr_cnt_d;
    logic [31:0] stat_rd_cnt_q, stat_rd_cnt_d;

    always_comb begin
        stat_wr_cnt_d = stat_wr_cnt_q + ((wd_pend_q && bus.app_wdf_rdy) ? 32'd1 : 32'd0);
        stat_rd_cnt_d = stat_rd_cnt_q + (fifo_push ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stat_wr_cnt_q <= '0;
            stat_rd_cnt_q <= '0;
        end else begin
            stat_wr_cnt_q <= stat_wr_cnt_d;
            stat_rd_cnt_q <= stat_rd_cnt_d;
        end
    end

    assign stat_wr_cnt = stat_wr_cnt_q;
    assign stat_rd_cnt = stat_rd_cnt_q;
`endif
endmodule
